// File: rtl/i2s_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_cfg_ctrl_if
// Purpose  : Bundles the configuration request port, the generator control
//            outputs and the WS feedback of the I2S reconfiguration
//            sequencer.
// Modports : slave  - the sequencer (accepts requests, drives the generator)
//            master - the register side / environment driving requests
// Signals  : req_valid_i, req_ready_o, req_en_i, req_pol_i, req_chl_i,
//            req_div_i, ws_i, en_o, pol_o, chl_o, div_o, done_o, timeout_o
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_cfg_ctrl_if #(
  parameter int DIV_WIDTH = 16
) ();

  // Request channel
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_en_i;
  logic                 req_pol_i;
  logic                 req_chl_i;
  logic [DIV_WIDTH-1:0] req_div_i;

  // Generator feedback
  logic                 ws_i;

  // Generator control
  logic                 en_o;
  logic                 pol_o;
  logic                 chl_o;
  logic [DIV_WIDTH-1:0] div_o;

  // Status pulses
  logic                 done_o;
  logic                 timeout_o;

  modport slave (
    input  req_valid_i,
    input  req_en_i,
    input  req_pol_i,
    input  req_chl_i,
    input  req_div_i,
    input  ws_i,
    output req_ready_o,
    output en_o,
    output pol_o,
    output chl_o,
    output div_o,
    output done_o,
    output timeout_o
  );

  modport master (
    output req_valid_i,
    output req_en_i,
    output req_pol_i,
    output req_chl_i,
    output req_div_i,
    output ws_i,
    input  req_ready_o,
    input  en_o,
    input  pol_o,
    input  chl_o,
    input  div_o,
    input  done_o,
    input  timeout_o
  );

endinterface
`default_nettype wire

// File: rtl/i2s_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2s_cfg_ctrl
// Purpose  : Reconfiguration sequencer for the I2S clock generator. Accepts
//            new settings over a valid/ready port, waits for a frame
//            boundary when the generator is running, holds the generator
//            disabled for SETTLE_CYC cycles, then loads the new settings.
// Ports    : clk_i - MCLK domain clock
//            rst_i - synchronous active-high reset
//            bus   - i2s_cfg_ctrl_if.slave (request port, generator control,
//                    WS feedback, done/timeout pulses)
// Params   : DIV_WIDTH, DIV_RST, SETTLE_CYC (>=1), TIMEOUT_CYC
// Revision : 1.0 - initial release
// ============================================================================
module i2s_cfg_ctrl #(
  parameter int DIV_WIDTH   = 16,
  parameter int DIV_RST     = 1,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic            clk_i,
  input  logic            rst_i,
  i2s_cfg_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_FRM = 2'd1,
    S_HOLD     = 2'd2,
    S_APPLY    = 2'd3
  } state_t;

  localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int c_ST_W = $clog2(SETTLE_CYC + 1);

  localparam logic [c_TO_W-1:0]    c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);
  localparam logic [c_ST_W-1:0]    c_ST_LAST = c_ST_W'(SETTLE_CYC - 1);
  localparam logic [DIV_WIDTH-1:0] c_DIV_RST = DIV_WIDTH'(DIV_RST);

  state_t               r_state;
  logic                 r_ws_q;

  // Generator-facing outputs, all registered
  logic                 r_en;
  logic                 r_pol;
  logic                 r_chl;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_timeout;

  // Shadow copy of the accepted request
  logic                 r_sh_en;
  logic                 r_sh_pol;
  logic                 r_sh_chl;
  logic [DIV_WIDTH-1:0] r_sh_div;

  logic [c_TO_W-1:0]    r_to_cnt;
  logic [c_ST_W-1:0]    r_st_cnt;

  logic                 w_accept;
  logic                 w_frame_end;
  logic                 w_to_hit;
  logic                 w_settled;

  assign w_accept    = bus.req_valid_i & r_ready;
  // WS was in the second (non-idle) half and has just returned to idle.
  assign w_frame_end = (r_ws_q == ~r_pol) && (bus.ws_i == r_pol);
  assign w_to_hit    = (r_to_cnt == c_TO_LAST);
  assign w_settled   = (r_st_cnt == c_ST_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_ws_q    <= 1'b0;
      r_en      <= 1'b0;
      r_pol     <= 1'b0;
      r_chl     <= 1'b0;
      r_div     <= c_DIV_RST;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_sh_en   <= 1'b0;
      r_sh_pol  <= 1'b0;
      r_sh_chl  <= 1'b0;
      r_sh_div  <= c_DIV_RST;
      r_to_cnt  <= '0;
      r_st_cnt  <= '0;
    end else begin
      r_ws_q    <= bus.ws_i;
      // Status outputs are single-cycle pulses by default.
      r_done    <= 1'b0;
      r_timeout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sh_en  <= bus.req_en_i;
            r_sh_pol <= bus.req_pol_i;
            r_sh_chl <= bus.req_chl_i;
            r_sh_div <= bus.req_div_i;
            r_ready  <= 1'b0;
            r_to_cnt <= '0;
            r_st_cnt <= '0;
            // A stopped generator has no frame to finish.
            r_state  <= r_en ? S_WAIT_FRM : S_HOLD;
          end
        end

        S_WAIT_FRM: begin
          // Frame end takes priority over a timeout in the same cycle.
          if (w_frame_end) begin
            r_en     <= 1'b0;
            r_st_cnt <= '0;
            r_state  <= S_HOLD;
          end else if (w_to_hit) begin
            r_en      <= 1'b0;
            r_timeout <= 1'b1;
            r_st_cnt  <= '0;
            r_state   <= S_HOLD;
          end else begin
            // Cannot wrap: the terminal count always leaves this state.
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          r_en <= 1'b0;
          if (w_settled) begin
            // The generator is disabled here, so the settings may change
            // without disturbing a frame.
            r_pol   <= r_sh_pol;
            r_chl   <= r_sh_chl;
            r_div   <= r_sh_div;
            r_done  <= 1'b1;
            r_state <= S_APPLY;
          end else begin
            r_st_cnt <= r_st_cnt + 1'b1;
          end
        end

        S_APPLY: begin
          r_en    <= r_sh_en;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_en    <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.en_o        = r_en;
  assign bus.pol_o       = r_pol;
  assign bus.chl_o       = r_chl;
  assign bus.div_o       = r_div;
  assign bus.done_o      = r_done;
  assign bus.timeout_o   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_i2s_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_cfg_ctrl
// Purpose  : Directed self-checking bench for i2s_cfg_ctrl (SETTLE_CYC=4,
//            TIMEOUT_CYC=16, DIV_RST=1). WS is driven directly by the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_cfg_ctrl;

  localparam int DIV_WIDTH = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  i2s_cfg_ctrl_if #(.DIV_WIDTH(DIV_WIDTH)) bus ();

  i2s_cfg_ctrl #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DIV_RST     (1),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are then stable for sampling and inputs
  // written afterwards are seen by the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic en, input logic pol,
                           input logic chl, input logic [DIV_WIDTH-1:0] div);
    bus.req_valid_i = v;
    bus.req_en_i    = en;
    bus.req_pol_i   = pol;
    bus.req_chl_i   = chl;
    bus.req_div_i   = div;
  endtask

  task automatic test_reset();
    int dones;
    rst = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    bus.ws_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (bus.en_o !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", bus.en_o); end
    n_cmp++; if (bus.pol_o !== 1'b0 || bus.chl_o !== 1'b0) begin n_err++; $display("FAIL reset_pol_chl: got %b%b want 00", bus.pol_o, bus.chl_o); end
    n_cmp++; if (bus.div_o !== 16'd1) begin n_err++; $display("FAIL reset_div: got %0d want 1", bus.div_o); end
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
    n_cmp++; if (bus.timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", bus.timeout_o); end
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done_o !== 1'b0) dones++;
      step();
    end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL idle_no_done: got %0d pulses want 0", dones); end
  endtask

  task automatic test_stopped_start();
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 16'd3);
    step();                                   // E0: accepted
    drive_req(1'b0, 1'b0, 1'b1, 1'b1, 16'd9); // must be ignored
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL start_ready_low: got %b want 0", bus.req_ready_o); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (bus.div_o !== 16'd1 || bus.done_o !== 1'b0 || bus.en_o !== 1'b0) begin
        n_err++; $display("FAIL start_hold%0d: div=%0d done=%b en=%b want div=1 done=0 en=0", i, bus.div_o, bus.done_o, bus.en_o);
      end
    end
    step();                                   // E0+4
    n_cmp++; if (bus.div_o !== 16'd3 || bus.done_o !== 1'b1 || bus.en_o !== 1'b0) begin
      n_err++; $display("FAIL start_apply: div=%0d done=%b en=%b want div=3 done=1 en=0", bus.div_o, bus.done_o, bus.en_o);
    end
    step();                                   // E0+5
    n_cmp++; if (bus.en_o !== 1'b1 || bus.req_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
      n_err++; $display("FAIL start_enable: en=%b ready=%b done=%b want 1 1 0", bus.en_o, bus.req_ready_o, bus.done_o);
    end
    n_cmp++; if (bus.pol_o !== 1'b0 || bus.chl_o !== 1'b0 || bus.div_o !== 16'd3) begin
      n_err++; $display("FAIL start_shadow: pol=%b chl=%b div=%0d want 0 0 3", bus.pol_o, bus.chl_o, bus.div_o);
    end
  endtask

  task automatic test_running_change();
    bus.ws_i = 1'b1;                          // second half-frame
    step();
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 16'd7);
    step();                                   // accepted mid-frame
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (bus.en_o !== 1'b1 || bus.div_o !== 16'd3) begin
        n_err++; $display("FAIL run_wait%0d: en=%b div=%0d want en=1 div=3", i, bus.en_o, bus.div_o);
      end
    end
    bus.ws_i = 1'b0;                          // back to idle level
    step();                                   // F: frame end sampled
    n_cmp++; if (bus.en_o !== 1'b0) begin n_err++; $display("FAIL run_en_fall: got %b want 0", bus.en_o); end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++; if (bus.en_o !== 1'b0 || bus.done_o !== (i == 4) || bus.timeout_o !== 1'b0) begin
        n_err++; $display("FAIL run_low%0d: en=%b done=%b to=%b", i, bus.en_o, bus.done_o, bus.timeout_o);
      end
    end
    n_cmp++; if (bus.div_o !== 16'd7) begin n_err++; $display("FAIL run_div: got %0d want 7", bus.div_o); end
    step();                                   // F+5
    n_cmp++; if (bus.en_o !== 1'b1 || bus.div_o !== 16'd7) begin
      n_err++; $display("FAIL run_en_rise: en=%b div=%0d want 1 7", bus.en_o, bus.div_o);
    end
  endtask

  task automatic test_timeout();
    int to_seen;
    // WS stuck at ~pol: no frame end ever.
    bus.ws_i = 1'b1;
    step();
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 16'd5);
    step();                                   // E0
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    to_seen = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (bus.timeout_o !== 1'b0 || bus.en_o !== 1'b1) to_seen++;
    end
    n_cmp++; if (to_seen !== 0) begin n_err++; $display("FAIL to_early: got %0d bad cycles want 0", to_seen); end
    step();                                   // E0+16: 16th wait cycle ends
    n_cmp++; if (bus.timeout_o !== 1'b1 || bus.en_o !== 1'b0) begin
      n_err++; $display("FAIL to_pulse: to=%b en=%b want 1 0", bus.timeout_o, bus.en_o);
    end
    step();
    n_cmp++; if (bus.timeout_o !== 1'b0) begin n_err++; $display("FAIL to_one_cycle: got %b want 0", bus.timeout_o); end
    step(); step(); step();                   // E0+20
    n_cmp++; if (bus.done_o !== 1'b1 || bus.div_o !== 16'd5) begin
      n_err++; $display("FAIL to_done: done=%b div=%0d want 1 5", bus.done_o, bus.div_o);
    end
    step();
    n_cmp++; if (bus.en_o !== 1'b1 || bus.req_ready_o !== 1'b1) begin
      n_err++; $display("FAIL to_resume: en=%b ready=%b want 1 1", bus.en_o, bus.req_ready_o);
    end

    // Frame end on the very last wait cycle beats the timeout.
    drive_req(1'b1, 1'b1, 1'b0, 1'b0, 16'd6);
    step();                                   // E1
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 15; i++) step();
    bus.ws_i = 1'b0;
    step();                                   // E1+16: both conditions
    n_cmp++; if (bus.timeout_o !== 1'b0 || bus.en_o !== 1'b0) begin
      n_err++; $display("FAIL to_tie: to=%b en=%b want 0 0", bus.timeout_o, bus.en_o);
    end
    for (int i = 1; i <= 5; i++) step();
    n_cmp++; if (bus.en_o !== 1'b1 || bus.div_o !== 16'd6) begin
      n_err++; $display("FAIL to_tie_apply: en=%b div=%0d want 1 6", bus.en_o, bus.div_o);
    end
  endtask

  task automatic test_reset_mid_hold();
    int bad;
    bus.ws_i = 1'b1;
    step();
    drive_req(1'b1, 1'b1, 1'b1, 1'b1, 16'd9);
    step();
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    bus.ws_i = 1'b0;
    step();                                   // frame end -> HOLD
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus.en_o !== 1'b0 || bus.pol_o !== 1'b0 || bus.chl_o !== 1'b0 || bus.div_o !== 16'd1 ||
                 bus.req_ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.timeout_o !== 1'b0) begin
      n_err++; $display("FAIL rst_hold_values: en=%b pol=%b chl=%b div=%0d rdy=%b done=%b to=%b",
                        bus.en_o, bus.pol_o, bus.chl_o, bus.div_o, bus.req_ready_o, bus.done_o, bus.timeout_o);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done_o !== 1'b0 || bus.div_o !== 16'd1 || bus.pol_o !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rst_hold_discard: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    // Generator stopped; A = {en0,pol1,chl1,0x11}, B = {en1,pol0,chl1,0x22}
    drive_req(1'b1, 1'b0, 1'b1, 1'b1, 16'h0011);
    step();                                   // E0: A accepted
    drive_req(1'b1, 1'b1, 1'b0, 1'b1, 16'h0022);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (bus.done_o === 1'b1) dones++;
    end
    n_cmp++; if (bus.done_o !== 1'b1 || bus.div_o !== 16'h0011 || bus.pol_o !== 1'b1 || bus.chl_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_a_apply: done=%b div=%h pol=%b chl=%b want 1 0011 1 1", bus.done_o, bus.div_o, bus.pol_o, bus.chl_o);
    end
    step();                                   // E0+5: IDLE, B pending on valid
    n_cmp++; if (bus.en_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_a_idle: en=%b ready=%b want 0 1", bus.en_o, bus.req_ready_o);
    end
    step();                                   // E0+6: B accepted
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_b_accept: ready=%b want 0", bus.req_ready_o); end
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (bus.done_o === 1'b1) dones++;
    end
    n_cmp++; if (bus.div_o !== 16'h0022 || bus.pol_o !== 1'b0 || bus.chl_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_b_apply: div=%h pol=%b chl=%b want 0022 0 1", bus.div_o, bus.pol_o, bus.chl_o);
    end
    step();
    n_cmp++; if (bus.en_o !== 1'b1 || bus.req_ready_o !== 1'b1) begin
      n_err++; $display("FAIL b2b_b_enable: en=%b ready=%b want 1 1", bus.en_o, bus.req_ready_o);
    end
    n_cmp++; if (dones !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
  endtask

  task automatic test_disable_running();
    // Same settings, enable cleared: full sequence still runs.
    bus.ws_i = 1'b1;
    step();
    drive_req(1'b1, 1'b0, 1'b0, 1'b1, 16'h0022);
    step();
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    step();
    n_cmp++; if (bus.en_o !== 1'b1) begin n_err++; $display("FAIL dis_wait: en=%b want 1", bus.en_o); end
    bus.ws_i = 1'b0;
    step();                                   // F
    n_cmp++; if (bus.en_o !== 1'b0) begin n_err++; $display("FAIL dis_fall: en=%b want 0", bus.en_o); end
    step(); step(); step(); step();           // F+4
    n_cmp++; if (bus.done_o !== 1'b1) begin n_err++; $display("FAIL dis_done: done=%b want 1", bus.done_o); end
    step();                                   // F+5
    n_cmp++; if (bus.en_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.div_o !== 16'h0022) begin
      n_err++; $display("FAIL dis_final: en=%b ready=%b div=%h want 0 1 0022", bus.en_o, bus.req_ready_o, bus.div_o);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.ws_i = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    test_reset();
    test_stopped_start();
    test_running_change();
    test_timeout();
    test_reset_mid_hold();
    test_back_to_back();
    test_disable_running();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_cfg_ctrl.md
# i2s_cfg_ctrl

Reconfiguration sequencer for the I2S clock generator. It accepts new clock settings (enable, polarity, channel width, divider) over a valid/ready request port. While the generator is running, it applies a change only at a frame boundary. Before loading new settings it holds the generator disabled for a programmable settle time, so SCK/WS never produce a truncated half-frame or a runt pulse. It sits between the register interface and the generator's `en/pol/chl/div` inputs, and observes the generator's WS output.

## Interface
- `DIV_WIDTH`, default 16: divider width; matches the generator's divider input.
- `DIV_RST`, default 1: divider value driven out of reset.
- `SETTLE_CYC`, default 4: number of cycles `en_o` is held low before new settings are applied. Legal range is ≥1.
- `TIMEOUT_CYC`, default 65535: maximum number of cycles to wait for a frame boundary before forcing the change.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  MCLK domain clock.
- `rst_i`  in  1  synchronous active-high reset.
- `req_valid_i`  in  1  configuration request valid.
- `req_ready_o`  out  1  controller idle; ready to accept a request.
- `req_en_i`  in  1  requested generator enable.
- `req_pol_i`  in  1  requested idle polarity.
- `req_chl_i`  in  1  requested channel width (0 = 16-bit, 1 = 32-bit).
- `req_div_i`  in  DIV_WIDTH  requested divider.
- `ws_i`  in  1  WS from the generator.
- `en_o`  out  1  generator enable.
- `pol_o`  out  1  generator polarity.
- `chl_o`  out  1  generator channel width.
- `div_o`  out  DIV_WIDTH  generator divider.
- `done_o`  out  1  one-cycle pulse: request applied.
- `timeout_o`  out  1  one-cycle pulse: frame boundary not seen; change forced.

## Operation
- **Reset values:** `en_o`=0, `pol_o`=0, `chl_o`=0, `div_o`=DIV_RST, `req_ready_o`=1, `done_o`=0, `timeout_o`=0, state IDLE. A reset taken mid-sequence discards the pending request.
- **Shadow capture:** `req_*` fields are captured into shadow registers on acceptance (`req_valid_i & req_ready_o`). After acceptance, later changes on `req_*` are ignored.
- **Frame end detection:** `ws_i` is registered into `ws_q`. A frame end is `ws_q == ~pol_o && ws_i == pol_o`, i.e. WS returns to its idle level after the second half-frame.
- **States:**
  - IDLE: `req_ready_o`=1. On acceptance, go to WAIT_FRM if `en_o`=1, otherwise go to HOLD.
  - WAIT_FRM: a timeout counter increments each cycle.
    - On frame end, go to HOLD.
    - If the counter reaches TIMEOUT_CYC−1 without a frame end, pulse `timeout_o` and go to HOLD.
    - If frame end and timeout occur in the same cycle, frame end wins and `timeout_o` stays 0.
  - HOLD: `en_o`=0 throughout. A settle counter runs for exactly SETTLE_CYC cycles, then the state goes to APPLY. This lets the generator reload its counters and drive SCK/WS to pol.
  - APPLY: exactly 1 cycle.
    - `pol_o/chl_o/div_o` already hold the shadow values; they are loaded on the edge entering APPLY.
    - `done_o`=1.
    - `en_o` is loaded with the shadow enable on the edge leaving APPLY.
    - Next state is IDLE.
- **No shortcut for unchanged settings:** a request identical to the current configuration still runs the full sequence.
- **Disable requests:** a request with `req_en_i`=0 while running waits for frame end, then leaves `en_o`=0.
- **Output stability:** `pol_o/chl_o/div_o` never change while `en_o`=1.
- **Counter widths:** both counters are sized `$clog2(max+1)`. Counters reset to 0 on state entry and never wrap.

## Timing
- **Stopped generator (`en_o`=0):**
  - Acceptance at edge E0.
  - HOLD occupies the cycles after E0 through E0+SETTLE_CYC.
  - New `pol/chl/div` are visible after edge E0+SETTLE_CYC, and `done_o` is high in that cycle.
  - `en_o` and `req_ready_o`=1 are visible after edge E0+SETTLE_CYC+1.
- **Running generator:** `en_o` falls at the edge that samples the frame end. The rest of the sequence matches the stopped case, measured from that edge.
- **Ready/valid:** `req_ready_o` is low from the edge after acceptance until IDLE is re-entered. A `req_valid_i` held high while not ready has no effect and is accepted in the first IDLE cycle.
- **Back-to-back:** throughput is one request per SETTLE_CYC+2 cycles minimum (stopped generator).

## Test plan
- Reset then idle: `en_o`=0, `div_o`=DIV_RST, `req_ready_o`=1; no `done_o` for 100 cycles.
- Stopped start, SETTLE_CYC=4: request {en=1, pol=0, chl=0, div=3} at E0.
  - `div_o`=3 after E0+4 with `done_o`=1.
  - `en_o`=1 after E0+5.
- Running change: with `chl_o`=0 running, request div=7 mid-frame.
  - `en_o` stays 1 until `ws_i` returns to pol, then falls.
  - `en_o` is low for exactly 5 cycles, then rises with `div_o`=7.
  - No WS pulse is shorter than the configured half-frame.
- Timeout: TIMEOUT_CYC=16, `ws_i` tied to ~pol, running, request issued.
  - `timeout_o` pulses on wait cycle 16.
  - Sequence completes with `done_o`=1.
- Reset mid-HOLD: `rst_i` asserted during HOLD.
  - Next cycle shows all reset values; the shadow request is never applied.
- Held valid: `req_valid_i` held high across two requests A, B.
  - A is applied, then B is accepted in the first IDLE cycle.
  - `done_o` pulses twice; the final outputs equal B.
